// File: rtl/iob_fifo_pkg.sv
// Shared constants and helpers for the iob_fifo_sync_ctrl FIFO controller.
package iob_fifo_pkg;

  // Number of words held by a FIFO whose RAM has addr_w address bits.
  function automatic int unsigned FIFO_DEPTH(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int unsigned LEVEL_W(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

  // Default almost-empty threshold (level at or below which it asserts).
  localparam int unsigned ALM_EMPTY_LVL_DEF = 1;
  // Default almost-full threshold sits this many words below full.
  localparam int unsigned ALM_FULL_MARGIN_DEF = 1;

endpackage

// File: rtl/iob_fifo_sync_ctrl_if.sv
// Bus bundle of iob_fifo_sync_ctrl: user write/read handshake, status and the
// external RAM ports. The almost-full/empty flags exist only when
// IOB_FIFO_SYNC_CTRL_ALMOST_EN is defined.
interface iob_fifo_sync_ctrl_if
  import iob_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);

  logic                        w_en_i;
  logic [DATA_W-1:0]           w_data_i;
  logic                        full_o;
  logic                        r_en_i;
  logic [DATA_W-1:0]           r_data_o;
  logic                        r_valid_o;
  logic                        empty_o;
  logic [LEVEL_W(ADDR_W)-1:0]  level_o;
  logic                        overflow_o;
  logic                        underflow_o;
  logic                        ext_mem_w_en_o;
  logic [ADDR_W-1:0]           ext_mem_w_addr_o;
  logic [DATA_W-1:0]           ext_mem_w_data_o;
  logic                        ext_mem_r_en_o;
  logic [ADDR_W-1:0]           ext_mem_r_addr_o;
  logic [DATA_W-1:0]           ext_mem_r_data_i;
`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
  logic                        almost_full_o;
  logic                        almost_empty_o;
`endif

  // FIFO controller side
  modport slave (
    input  w_en_i, w_data_i, r_en_i, ext_mem_r_data_i,
`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
    output almost_full_o, almost_empty_o,
`endif
    output full_o, r_data_o, r_valid_o, empty_o, level_o, overflow_o, underflow_o,
    output ext_mem_w_en_o, ext_mem_w_addr_o, ext_mem_w_data_o,
    output ext_mem_r_en_o, ext_mem_r_addr_o
  );

  // User / RAM side
  modport master (
    output w_en_i, w_data_i, r_en_i, ext_mem_r_data_i,
`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
    input  almost_full_o, almost_empty_o,
`endif
    input  full_o, r_data_o, r_valid_o, empty_o, level_o, overflow_o, underflow_o,
    input  ext_mem_w_en_o, ext_mem_w_addr_o, ext_mem_w_data_o,
    input  ext_mem_r_en_o, ext_mem_r_addr_o
  );

endinterface

// File: rtl/iob_fifo_level_ctrl.sv
// Occupancy counter and registered full/empty flags of the FIFO. With
// IOB_FIFO_SYNC_CTRL_ALMOST_EN defined it also produces almost_full/empty.
// All flags are registered from the next level so they line up with it.
module iob_fifo_level_ctrl
  import iob_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
  ,
  parameter int unsigned ALM_FULL_LVL  = FIFO_DEPTH(ADDR_W) - ALM_FULL_MARGIN_DEF,
  parameter int unsigned ALM_EMPTY_LVL = ALM_EMPTY_LVL_DEF
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_acc,
  input  logic                       r_acc,
  output logic [LEVEL_W(ADDR_W)-1:0] level,
  output logic                       full,
  output logic                       empty
`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
  ,
  output logic                       almost_full,
  output logic                       almost_empty
`endif
);

  localparam int unsigned    LW      = LEVEL_W(ADDR_W);
  localparam logic [LW-1:0]  DEPTH_L = LW'(FIFO_DEPTH(ADDR_W));

  logic [LW-1:0] level_nxt;

  // Next occupancy: a simultaneous accepted write and read cancel out.
  always_comb begin
    level_nxt = level;
    if (w_acc && !r_acc) begin
      level_nxt = level + LW'(1);
    end else if (r_acc && !w_acc) begin
      level_nxt = level - LW'(1);
    end
  end

  // Level register with full/empty flags derived from the next level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == DEPTH_L);
    end
  end

`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
  // Threshold flags, also registered from the next level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_nxt >= LW'(ALM_FULL_LVL));
      almost_empty <= (level_nxt <= LW'(ALM_EMPTY_LVL));
    end
  end
`endif

endmodule

// File: rtl/iob_fifo_sync_ctrl.sv
// Single-clock FIFO controller in front of an external two-port RAM with a
// registered (1-cycle) read port. Owns the pointers, occupancy and flags and
// drives both RAM ports; data passes straight through.
// Optional almost-full/empty flags: define IOB_FIFO_SYNC_CTRL_ALMOST_EN.
module iob_fifo_sync_ctrl
  import iob_fifo_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned ALM_FULL_LVL  = FIFO_DEPTH(ADDR_W) - ALM_FULL_MARGIN_DEF,
  parameter int unsigned ALM_EMPTY_LVL = ALM_EMPTY_LVL_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  iob_fifo_sync_ctrl_if.slave  bus
);

  // Elaboration-time sanity checks on the configuration.
  if (DATA_W != $bits(bus.w_data_i) || ADDR_W != $bits(bus.ext_mem_w_addr_o)) begin : g_bad_bus_w
    $error("iob_fifo_sync_ctrl: bus widths do not match DATA_W/ADDR_W");
  end
  if (ALM_FULL_LVL > FIFO_DEPTH(ADDR_W) || ALM_EMPTY_LVL > FIFO_DEPTH(ADDR_W)) begin : g_bad_alm_lvl
    $error("iob_fifo_sync_ctrl: almost thresholds exceed FIFO depth");
  end

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic              w_acc;
  logic              r_acc;
  logic              full;
  logic              empty;

  // Accept against the registered flags only; reset blocks both RAM enables
  // even before the flags hold defined values.
  always_comb begin
    w_acc                = rst_n_i & bus.w_en_i & ~full;
    r_acc                = rst_n_i & bus.r_en_i & ~empty;
    bus.ext_mem_w_en_o   = w_acc;
    bus.ext_mem_w_addr_o = w_ptr;
    bus.ext_mem_w_data_o = bus.w_data_i;
    bus.ext_mem_r_en_o   = r_acc;
    bus.ext_mem_r_addr_o = r_ptr;
    bus.r_data_o         = bus.ext_mem_r_data_i;
    bus.full_o           = full;
    bus.empty_o          = empty;
  end

  // Pointers wrap naturally at the RAM size; read-valid and error pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      w_ptr           <= '0;
      r_ptr           <= '0;
      bus.r_valid_o   <= 1'b0;
      bus.overflow_o  <= 1'b0;
      bus.underflow_o <= 1'b0;
    end else begin
      if (w_acc) begin
        w_ptr <= w_ptr + ADDR_W'(1);
      end
      if (r_acc) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
      bus.r_valid_o   <= r_acc;
      bus.overflow_o  <= bus.w_en_i & full;
      bus.underflow_o <= bus.r_en_i & empty;
    end
  end

  iob_fifo_level_ctrl #(
    .ADDR_W        (ADDR_W)
`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
    ,
    .ALM_FULL_LVL  (ALM_FULL_LVL),
    .ALM_EMPTY_LVL (ALM_EMPTY_LVL)
`endif
  ) u_level_ctrl (
    .clk          (clk_i),
    .rst_n        (rst_n_i),
    .w_acc        (w_acc),
    .r_acc        (r_acc),
    .level        (bus.level_o),
    .full         (full),
    .empty        (empty)
`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
    ,
    .almost_full  (bus.almost_full_o),
    .almost_empty (bus.almost_empty_o)
`endif
  );

endmodule

// File: tb/tb_iob_fifo_sync_ctrl.sv
// Bench for iob_fifo_sync_ctrl (DATA_W=8, ADDR_W=2, depth 4) with a simple
// registered-read RAM model, a queue-based reference FIFO and directed traffic.
module tb_iob_fifo_sync_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  iob_fifo_sync_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  iob_fifo_sync_ctrl #(
    .DATA_W        (DW),
    .ADDR_W        (AW),
    .ALM_FULL_LVL  (3),
    .ALM_EMPTY_LVL (1)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // External RAM: one write port, registered read port.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.ext_mem_w_en_o) ram[bus.ext_mem_w_addr_o] <= bus.ext_mem_w_data_o;
    if (bus.ext_mem_r_en_o) bus.ext_mem_r_data_i <= ram[bus.ext_mem_r_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference FIFO: a queue of words plus counts of accepted writes/reads.
  logic [DW-1:0] mq [$];
  int unsigned   m_sz;
  int unsigned   wr_tot, rd_tot;
  bit            m_live = 1'b0;
  bit            m_rvalid, m_ovf, m_udf;
  logic [DW-1:0] m_rdata;

  always @(posedge clk) begin
    m_sz   = mq.size();
    m_live = 1'b1;
    if (!rst_n) begin
      mq.delete();
      wr_tot   = 0;
      rd_tot   = 0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
    end else begin
      m_ovf    = bus.w_en_i && (m_sz == DEPTH);
      m_udf    = bus.r_en_i && (m_sz == 0);
      m_rvalid = bus.r_en_i && (m_sz != 0);
      if (m_rvalid) begin
        m_rdata = mq.pop_front();
        rd_tot++;
      end
      if (bus.w_en_i && (m_sz < DEPTH)) begin
        mq.push_back(bus.w_data_i);
        wr_tot++;
      end
    end
  end

  // Every-cycle comparison against the reference, away from the active edge.
  int unsigned c_sz;
  bit          c_wen, c_ren;
  always @(negedge clk) begin
    if (m_live) begin
      c_sz  = mq.size();
      c_wen = rst_n && bus.w_en_i && (c_sz < DEPTH);
      c_ren = rst_n && bus.r_en_i && (c_sz != 0);
      chk("level", 32'(bus.level_o), c_sz);
      chk("empty", 32'(bus.empty_o), 32'(c_sz == 0));
      chk("full", 32'(bus.full_o), 32'(c_sz == DEPTH));
      chk("r_valid", 32'(bus.r_valid_o), 32'(m_rvalid));
      if (m_rvalid) chk("r_data", 32'(bus.r_data_o), 32'(m_rdata));
      chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow_o), 32'(m_udf));
      chk("mem_w_en", 32'(bus.ext_mem_w_en_o), 32'(c_wen));
      if (c_wen) begin
        chk("mem_w_addr", 32'(bus.ext_mem_w_addr_o), wr_tot % DEPTH);
        chk("mem_w_data", 32'(bus.ext_mem_w_data_o), 32'(bus.w_data_i));
      end
      chk("mem_r_en", 32'(bus.ext_mem_r_en_o), 32'(c_ren));
      if (c_ren) chk("mem_r_addr", 32'(bus.ext_mem_r_addr_o), rd_tot % DEPTH);
`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
      chk("almost_full", 32'(bus.almost_full_o), 32'(c_sz >= 3));
      chk("almost_empty", 32'(bus.almost_empty_o), 32'(c_sz <= 1));
`endif
    end
  end

  task automatic drive(input bit rn, input bit w, input logic [DW-1:0] d, input bit r);
    @(negedge clk);
    #1;
    rst_n        = rn;
    bus.w_en_i   = w;
    bus.w_data_i = d;
    bus.r_en_i   = r;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    drive(1'b1, w, d, r);
    after_edge();
  endtask

  logic [DW-1:0] fill_dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [DW-1:0] sim_exp  [6] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3};

  initial begin
    #20000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.w_en_i   = 1'b0;
    bus.w_data_i = '0;
    bus.r_en_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(bus.level_o), 0);
    chk("rst_empty", 32'(bus.empty_o), 1);
    chk("rst_full", 32'(bus.full_o), 0);
    chk("rst_r_valid", 32'(bus.r_valid_o), 0);
    step(1'b0, 8'h00, 1'b0);

    // Fill to full.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fill_dat[i], 1'b0);
      chk("fill_level", 32'(bus.level_o), 32'(i + 1));
`ifdef IOB_FIFO_SYNC_CTRL_ALMOST_EN
      if (i == 0) chk("alm_empty_at1", 32'(bus.almost_empty_o), 1);
      if (i == 2) begin
        chk("alm_full_at3", 32'(bus.almost_full_o), 1);
        chk("alm_empty_at3", 32'(bus.almost_empty_o), 0);
      end
`endif
    end
    chk("fill_full", 32'(bus.full_o), 1);
    chk("mdl_size_full", mq.size(), 4);

    // Write while full is rejected.
    drive(1'b1, 1'b1, 8'h55, 1'b0);
    #1;
    chk("ovf_mem_w_en", 32'(bus.ext_mem_w_en_o), 0);
    after_edge();
    chk("ovf_pulse", 32'(bus.overflow_o), 1);
    chk("ovf_level", 32'(bus.level_o), 4);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_pulse_end", 32'(bus.overflow_o), 0);

    // Drain in order, data valid one cycle after each read.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      #1;
      if (i == 0) chk("rd_valid_before", 32'(bus.r_valid_o), 0);
      after_edge();
      chk("rd_valid", 32'(bus.r_valid_o), 1);
      chk("rd_data", 32'(bus.r_data_o), 32'(fill_dat[i]));
    end
    chk("drain_empty", 32'(bus.empty_o), 1);
    step(1'b0, 8'h00, 1'b0);
    chk("drain_valid_end", 32'(bus.r_valid_o), 0);

    // Read while empty is rejected.
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    #1;
    chk("udf_mem_r_en", 32'(bus.ext_mem_r_en_o), 0);
    after_edge();
    chk("udf_pulse", 32'(bus.underflow_o), 1);
    chk("udf_r_valid", 32'(bus.r_valid_o), 0);
    step(1'b0, 8'h00, 1'b0);
    chk("udf_pulse_end", 32'(bus.underflow_o), 0);

    // Level 2, then six simultaneous write+read cycles across the wrap.
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    chk("sim_start_level", 32'(bus.level_o), 2);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hB0 + 8'(i), 1'b1);
      chk("sim_level", 32'(bus.level_o), 2);
      chk("sim_valid", 32'(bus.r_valid_o), 1);
      chk("sim_data", 32'(bus.r_data_o), 32'(sim_exp[i]));
    end
    chk("sim_w_addr", 32'(bus.ext_mem_w_addr_o), 0);
    chk("sim_r_addr", 32'(bus.ext_mem_r_addr_o), 2);
    chk("mdl_size_sim", mq.size(), 2);

    // Reset for two cycles in the middle of traffic.
    drive(1'b0, 1'b1, 8'hC0, 1'b1);
    #1;
    chk("mrst_mem_w_en", 32'(bus.ext_mem_w_en_o), 0);
    chk("mrst_mem_r_en", 32'(bus.ext_mem_r_en_o), 0);
    after_edge();
    chk("mrst_drop_valid", 32'(bus.r_valid_o), 0);
    drive(1'b0, 1'b1, 8'hC1, 1'b1);
    after_edge();
    chk("mrst_level", 32'(bus.level_o), 0);
    chk("mrst_empty", 32'(bus.empty_o), 1);
    chk("mrst_full", 32'(bus.full_o), 0);
    chk("mrst_r_valid", 32'(bus.r_valid_o), 0);

    // Normal operation resumes after reset.
    step(1'b1, 8'h5A, 1'b0);
    chk("post_level", 32'(bus.level_o), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_valid", 32'(bus.r_valid_o), 1);
    chk("post_data", 32'(bus.r_data_o), 32'h5A);
    step(1'b0, 8'h00, 1'b0);
    chk("post_empty", 32'(bus.empty_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
